// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined MAC array.
// prod_bw : width of one signed lane product of an unsigned and a signed bw-bit operand
// sum_bw  : width of the signed sum of 'lanes' such products
// mode_e  : accumulate mode select (external partial sum or internal accumulator)
package mac_pkg;

    function automatic int prod_bw(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_bw(input int w, input int n);
        return prod_bw(w) + $clog2(n);
    endfunction

    typedef enum logic {
        MODE_EXT = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

endpackage

// File: rtl/mac_dot.sv
// Combinational lanes-wide dot product.
// Ports:
//   a   : lanes x bw unsigned activations, lane i at [i*bw +: bw]
//   b   : lanes x bw signed weights, lane i at [i*bw +: bw]
//   dot : signed sum of a_i * b_i at sum_bw(bw, lanes) bits
module mac_dot
    import mac_pkg::*;
#(
    parameter int bw    = 4,
    parameter int lanes = 4
) (
    input  logic [lanes*bw-1:0]                  a,
    input  logic [lanes*bw-1:0]                  b,
    output logic signed [sum_bw(bw, lanes)-1:0]  dot
);

    localparam int PW = prod_bw(bw);
    localparam int SW = sum_bw(bw, lanes);

    logic signed [PW-1:0] prod [lanes];

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        logic signed [PW-1:0] pa;
        logic signed [PW-1:0] pb;
        // activation zero-extended, weight sign-extended; the product fits in PW bits
        assign pa      = {{(PW-bw){1'b0}}, a[i*bw +: bw]};
        assign pb      = {{(PW-bw){b[i*bw+bw-1]}}, b[i*bw +: bw]};
        assign prod[i] = pa * pb;
    end

    always_comb begin
        dot = '0;
        for (int unsigned i = 0; i < lanes; i++) begin
            dot = dot + SW'(prod[i]);
        end
    end

endmodule

// File: rtl/mac_pipe_array.sv
// Three-stage pipelined N-lane MAC with valid/ready handshake and internal accumulator.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : input beat handshake (in_ready is the global pipeline enable)
//   a, b                 : lanes x bw activations (unsigned) and weights (signed)
//   c                    : external partial sum, used in MODE_EXT
//   acc_mode, acc_clr    : 0 = dot + c, 1 = dot + accumulator; clear accumulator for this beat
//   out_valid/out_ready  : result handshake
//   out                  : psum_bw-bit result, wraps modulo 2^psum_bw
module mac_pipe_array
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int lanes   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [lanes*bw-1:0]   a,
    input  logic [lanes*bw-1:0]   b,
    input  logic [psum_bw-1:0]    c,
    input  logic                  acc_mode,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [psum_bw-1:0]    out
);

    localparam int SW = sum_bw(bw, lanes);

    logic                  en;
    logic signed [SW-1:0]  dot1;
    logic [psum_bw-1:0]    dot_ext;
    logic [psum_bw-1:0]    acc_sum;

    // S1
    logic [lanes*bw-1:0]   a1_q, a1_d, b1_q, b1_d;
    logic [psum_bw-1:0]    c1_q, c1_d;
    mode_e                 mode1_q, mode1_d;
    logic                  clr1_q, clr1_d, v1_q, v1_d;
    // S2
    logic signed [SW-1:0]  dot2_q, dot2_d;
    logic [psum_bw-1:0]    c2_q, c2_d;
    mode_e                 mode2_q, mode2_d;
    logic                  clr2_q, clr2_d, v2_q, v2_d;
    // S3
    logic [psum_bw-1:0]    out_q, out_d, acc_q, acc_d;
    logic                  out_valid_q, out_valid_d;

    mac_dot #(.bw(bw), .lanes(lanes)) u_dot (
        .a   (a1_q),
        .b   (b1_q),
        .dot (dot1)
    );

    always_comb begin
        en      = !out_valid_q || out_ready;
        dot_ext = psum_bw'(dot2_q);
        acc_sum = '0;

        a1_d = a1_q;   b1_d = b1_q;   c1_d = c1_q;
        mode1_d = mode1_q;   clr1_d = clr1_q;   v1_d = v1_q;
        dot2_d = dot2_q;   c2_d = c2_q;
        mode2_d = mode2_q;   clr2_d = clr2_q;   v2_d = v2_q;
        out_d = out_q;   acc_d = acc_q;   out_valid_d = out_valid_q;

        // a single enable drives every stage so bubbles stay in place under stall
        if (en) begin
            a1_d    = a;
            b1_d    = b;
            c1_d    = c;
            mode1_d = mode_e'(acc_mode);
            clr1_d  = acc_clr;
            v1_d    = in_valid;

            dot2_d  = dot1;
            c2_d    = c1_q;
            mode2_d = mode1_q;
            clr2_d  = clr1_q;
            v2_d    = v1_q;

            out_valid_d = v2_q;
            if (v2_q) begin
                if (mode2_q == MODE_ACC) begin
                    acc_sum = (clr2_q ? '0 : acc_q) + dot_ext;
                    out_d   = acc_sum;
                    acc_d   = acc_sum;
                end else begin
                    out_d = c2_q + dot_ext;
                    if (clr2_q) begin
                        acc_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a1_q        <= '0;
            b1_q        <= '0;
            c1_q        <= '0;
            mode1_q     <= MODE_EXT;
            clr1_q      <= 1'b0;
            v1_q        <= 1'b0;
            dot2_q      <= '0;
            c2_q        <= '0;
            mode2_q     <= MODE_EXT;
            clr2_q      <= 1'b0;
            v2_q        <= 1'b0;
            out_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            c1_q        <= c1_d;
            mode1_q     <= mode1_d;
            clr1_q      <= clr1_d;
            v1_q        <= v1_d;
            dot2_q      <= dot2_d;
            c2_q        <= c2_d;
            mode2_q     <= mode2_d;
            clr2_q      <= clr2_d;
            v2_q        <= v2_d;
            out_q       <= out_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule
